// File: rtl/keypad_loader.sv
// Keypad entry front end for the microwave timer: debounced key capture,
// 3-digit BCD entry buffer and run/pause/done sequencing of the timer.
module keypad_loader #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int QUICK_TENS      = 3
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_zero,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       load,
  output logic       timer_en,
  output logic       done,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } st_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] QT = 4'(QUICK_TENS);

  st_t        st, st_n;
  logic       s1, s2, prev, armed;
  logic [CW-1:0] lowc;
  logic [1:0] cnt, cnt_n;
  logic [3:0] m_n, t_n, o_n;
  logic       load_n, err_n, en_n, done_n;
  logic       acc, is_dig, is_start, is_stop;

  assign acc      = s2 & ~prev & armed;
  assign is_dig   = key_code <= 4'd9;
  assign is_start = key_code == 4'hA;
  assign is_stop  = key_code == 4'hB;
  assign state    = st;

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    m_n    = mins;
    t_n    = sec_tens;
    o_n    = sec_ones;
    load_n = 1'b0;
    err_n  = 1'b0;
    en_n   = timer_en;
    done_n = done;
    unique case (st)
      IDLE, ENTRY: begin
        if (acc && is_dig) begin
          if (cnt == 2'd3) begin
            err_n = 1'b1;
          end else begin
            m_n   = sec_tens;
            t_n   = sec_ones;
            o_n   = key_code;
            cnt_n = cnt + 2'd1;
            st_n  = ENTRY;
          end
        end else if (acc && is_start) begin
          if (st == IDLE) begin
            m_n    = 4'd0;
            t_n    = QT;
            o_n    = 4'd0;
            load_n = 1'b1;
            en_n   = 1'b1;
            st_n   = RUN;
          end else if (sec_tens <= 4'd5 &&
                       {mins, sec_tens, sec_ones} != 12'd0) begin
            load_n = 1'b1;
            en_n   = 1'b1;
            st_n   = RUN;
          end else begin
            err_n = 1'b1;
            m_n   = 4'd0;
            t_n   = 4'd0;
            o_n   = 4'd0;
            cnt_n = 2'd0;
            st_n  = IDLE;
          end
        end else if (acc && is_stop && st == ENTRY) begin
          m_n   = 4'd0;
          t_n   = 4'd0;
          o_n   = 4'd0;
          cnt_n = 2'd0;
          st_n  = IDLE;
        end
      end
      RUN: begin
        // Completion outranks a STOP landing in the same cycle
        if (timer_zero) begin
          en_n   = 1'b0;
          done_n = 1'b1;
          st_n   = DONE;
        end else if (acc && is_stop) begin
          en_n = 1'b0;
          st_n = PAUSE;
        end
      end
      PAUSE: begin
        if (acc && is_start) begin
          en_n = 1'b1;
          st_n = RUN;
        end else if (acc && is_stop) begin
          m_n   = 4'd0;
          t_n   = 4'd0;
          o_n   = 4'd0;
          cnt_n = 2'd0;
          st_n  = IDLE;
        end
      end
      DONE: begin
        if (acc) begin
          done_n = 1'b0;
          m_n    = 4'd0;
          t_n    = 4'd0;
          o_n    = 4'd0;
          cnt_n  = 2'd0;
          st_n   = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      prev     <= 1'b0;
      armed    <= 1'b1;
      lowc     <= '0;
      st       <= IDLE;
      cnt      <= 2'd0;
      mins     <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      load     <= 1'b0;
      err      <= 1'b0;
      timer_en <= 1'b0;
      done     <= 1'b0;
    end else begin
      s1   <= key_valid;
      s2   <= s1;
      prev <= s2;
      // Re-arm only after an unbroken run of low samples
      if (acc) begin
        armed <= 1'b0;
        lowc  <= '0;
      end else if (!armed) begin
        if (s2) begin
          lowc <= '0;
        end else if (lowc == LAST) begin
          armed <= 1'b1;
          lowc  <= '0;
        end else begin
          lowc <= lowc + 1'b1;
        end
      end
      st       <= st_n;
      cnt      <= cnt_n;
      mins     <= m_n;
      sec_tens <= t_n;
      sec_ones <= o_n;
      load     <= load_n;
      err      <= err_n;
      timer_en <= en_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_keypad_loader.sv
// Directed bench for keypad_loader: entry, validation, pause/resume,
// debounce, completion priority and asynchronous reset.
module tb_keypad_loader;

  logic       clock = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       timer_zero = 1'b0;
  logic [3:0] mins, sec_tens, sec_ones;
  logic       load, timer_en, done, err;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  int load_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int l0, e0;

  keypad_loader dut (
    .clock(clock), .clrn(clrn),
    .key_valid(key_valid), .key_code(key_code),
    .timer_zero(timer_zero),
    .mins(mins), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .load(load), .timer_en(timer_en), .done(done), .err(err),
    .state(state)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (load) load_cnt++;
    if (err) err_cnt++;
    if (load && err) both_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clock);
    key_code = c;
    key_valid = 1'b1;
    repeat (20) @(negedge clock);
    key_valid = 1'b0;
    repeat (20) @(negedge clock);
  endtask

  task automatic digits(input string tag, input int exp);
    check(tag, {mins, sec_tens, sec_ones}, exp);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_out", {mins, sec_tens, sec_ones, load, timer_en,
                      done, err, state}, 0);
    clrn = 1'b1;
    repeat (2) @(negedge clock);

    // 1:30 entry and start
    l0 = load_cnt;
    press(4'd1); press(4'd3); press(4'd0);
    check("entry_state", state, 1);
    press(4'hA);
    digits("t1_digits", 12'h130);
    check("t1_load", load_cnt - l0, 1);
    check("t1_en", timer_en, 1);
    check("t1_state", state, 2);
    press(4'hB); press(4'hB);
    check("t1_idle", state, 0);

    // 0:99 rejected
    l0 = load_cnt; e0 = err_cnt;
    press(4'd9); press(4'd9); press(4'hA);
    check("t2_err", err_cnt - e0, 1);
    digits("t2_digits", 0);
    check("t2_state", state, 0);
    check("t2_en", timer_en, 0);
    check("t2_load", load_cnt - l0, 0);

    // quick start, pause, resume, clear
    l0 = load_cnt;
    press(4'hA);
    digits("t3_digits", 12'h030);
    check("t3_load", load_cnt - l0, 1);
    check("t3_state", state, 2);
    press(4'hB);
    check("t3_pause", state, 3);
    check("t3_pause_en", timer_en, 0);
    press(4'hA);
    check("t3_resume_en", timer_en, 1);
    check("t3_resume_st", state, 2);
    check("t3_resume_load", load_cnt - l0, 1);
    press(4'hB); press(4'hB);
    check("t3_idle", state, 0);
    digits("t3_clr", 0);

    // fourth digit overflow
    e0 = err_cnt;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("t4_err", err_cnt - e0, 1);
    digits("t4_digits", 12'h123);
    check("t4_state", state, 1);
    press(4'hB);

    // bouncing key 5 then clean key 7
    e0 = err_cnt;
    @(negedge clock);
    key_code = 4'd5;
    for (int i = 0; i < 10; i++) begin
      key_valid = ~key_valid;
      repeat (3) @(negedge clock);
    end
    key_valid = 1'b0;
    repeat (20) @(negedge clock);
    digits("t5_bounce", 12'h005);
    check("t5_err", err_cnt - e0, 0);
    press(4'd7);
    digits("t5_second", 12'h057);
    check("t5_state", state, 1);

    // STOP and timer_zero in the same cycle
    press(4'hA);
    check("t6_run", state, 2);
    @(negedge clock);
    key_code = 4'hB;
    key_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    timer_zero = 1'b1;
    @(negedge clock);
    timer_zero = 1'b0;
    repeat (17) @(negedge clock);
    key_valid = 1'b0;
    repeat (20) @(negedge clock);
    check("t6_state", state, 4);
    check("t6_done", done, 1);
    check("t6_en", timer_en, 0);
    press(4'd1);
    check("t6_done_clr", done, 0);
    check("t6_idle", state, 0);
    digits("t6_consumed", 0);

    // async reset mid-run
    press(4'hA);
    check("t7_run_en", timer_en, 1);
    @(negedge clock);
    #2 clrn = 1'b0;
    #1;
    check("t7_rst", {mins, sec_tens, sec_ones, load, timer_en,
                     done, err, state}, 0);
    check("no_load_err", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_loader.md
Name: keypad_loader

Overview:
- Operator-entry front end for the microwave countdown timer.
- Takes raw key presses from the keypad scanner. Assembles a 3-digit BCD time (M:S S) by shift-in entry and validates it.
- On START, presents the time to the timer with a one-cycle load strobe, then sequences timer enable through run, pause and done.
- Sits between the keypad scanner and the timer. It is the writer side of the timer's data/load interface.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synchronized-low cycles of key_valid required before the next press is accepted.
- QUICK_TENS, 3: sec_tens digit loaded by quick-start (START pressed with an empty buffer gives 0:30).

Ports:
- clock  input  1  system clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- key_valid  input  1  level from scanner, high while a key is held; asynchronous to clock.
- key_code  input  4  key identity: 0-9 digit, 4'hA START, 4'hB STOP/CLEAR, 4'hC-4'hF ignored. Stable while key_valid is high.
- timer_zero  input  1  timer countdown reached 0:00.
- mins  output  4  BCD minutes digit of the entry buffer.
- sec_tens  output  4  BCD tens-of-seconds digit.
- sec_ones  output  4  BCD ones-of-seconds digit.
- load  output  1  one-cycle strobe; digits are valid to the timer in that cycle.
- timer_en  output  1  timer count enable.
- done  output  1  level, cooking complete.
- err  output  1  one-cycle strobe on rejected entry.
- state  output  3  FSM state for display/debug: IDLE=0, ENTRY=1, RUN=2, PAUSE=3, DONE=4.

Behaviour:
- Reset (clrn low, asynchronous): all outputs 0, state IDLE, digit count 0, synchronizer 0, debounce armed. Reset mid-RUN drops timer_en immediately.
- Input path: key_valid passes through a 2-flop synchronizer.
  - A press is accepted in the cycle the synchronized value is 1 and the previous synchronized value was 0, while armed. key_code is sampled in that cycle.
  - Acceptance disarms. Re-arm requires DEBOUNCE_CYCLES consecutive synchronized-low cycles; any high restarts the count.
  - Latency: the action's registered outputs change 3 clock edges after key_valid rises.
- Digit shift (IDLE or ENTRY): mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit, count++, state ENTRY.
  - Fourth and later digits are dropped and pulse err; the buffer is unchanged.
  - Digits in RUN, PAUSE or DONE are ignored, no err.
- START in IDLE (buffer empty): load mins=0, sec_tens=QUICK_TENS, sec_ones=0; pulse load; timer_en=1; go to RUN.
- START in ENTRY:
  - Valid when sec_tens<=5 and the buffer is not 0:00. Then pulse load, timer_en=1, go to RUN.
  - Invalid: pulse err, clear the buffer and count, go to IDLE.
- STOP:
  - ENTRY: clear the buffer, go to IDLE.
  - RUN: timer_en=0, go to PAUSE.
  - PAUSE: clear the buffer, go to IDLE.
  - IDLE: no effect.
- START in PAUSE: timer_en=1, go to RUN, no load strobe.
- START in RUN: ignored.
- In RUN, timer_zero high: timer_en=0, done=1, go to DONE. timer_zero is ignored in all other states.
- DONE: any accepted key clears done and the buffer and goes to IDLE. That key is consumed and not otherwise acted on.
- Simultaneous accepted STOP and timer_zero in RUN: timer_zero wins, go to DONE.
- load and err are never high in the same cycle. load is high for exactly one cycle per RUN entry from IDLE or ENTRY.
- The digit registers hold the entered value through RUN, PAUSE and DONE. The timer owns the live count.

Test Plan:
- Reset then keys 1,3,0,START (each held 20 cycles, released 20) -> mins=1, sec_tens=3, sec_ones=0; load high exactly 1 cycle; timer_en=1; state=2.
- Keys 9,9,START -> sec_tens=9 invalid -> err 1 cycle, digits 0:00, state=0, timer_en=0, no load.
- Key START from IDLE -> mins=0, sec_tens=3, sec_ones=0, load pulse, state=2. Then STOP -> state=3, timer_en=0. Then START -> timer_en=1, no load. Then STOP, STOP -> state=0, digits 0:00.
- Keys 1,2,3,4 -> fourth key pulses err; digits remain 1:23, state=1.
- Bounce: key_valid toggles high/low every 3 cycles for 30 cycles on key 5 -> exactly one digit accepted (sec_ones=5). A second clean press after 16+ low cycles is accepted.
- In RUN, assert timer_zero in the same cycle an accepted STOP lands -> state=4, done=1, timer_en=0. Next key -> done=0, state=0. Assert clrn low mid-RUN -> all outputs 0 asynchronously.
